// File: rtl/cla_8_bit_pkg.sv
// Shared constants and operand type for the two-level carry-lookahead adder.
package cla_8_bit_pkg;

  localparam int CLA_WIDTH  = 8;
  localparam int CLA_GROUP  = 4;
  localparam int CLA_GROUPS = CLA_WIDTH / CLA_GROUP;

  typedef logic [CLA_WIDTH-1:0] operand_t;

endpackage

// File: rtl/cla_8_bit_cla_4bit.sv
// First-level lookahead group: four-bit sum plus group generate/propagate.
// Every internal carry is a flat sum-of-products of g, p and the group
// carry-in, so nothing ripples from one bit to the next.
module cla_4bit
  import cla_8_bit_pkg::*;
(
  input  logic [CLA_GROUP-1:0] a,
  input  logic [CLA_GROUP-1:0] b,
  input  logic                 ci,
  output logic [CLA_GROUP-1:0] s,
  output logic                 GG,
  output logic                 GP
);

  logic [CLA_GROUP-1:0] g;
  logic [CLA_GROUP-1:0] p;
  logic [CLA_GROUP-1:0] c;

  // Per-bit generate and propagate terms.
  genvar gi;
  generate
    for (gi = 0; gi < CLA_GROUP; gi++) begin : g_bit
      assign g[gi] = a[gi] & b[gi];
      assign p[gi] = a[gi] ^ b[gi];
    end
  endgenerate

  // Carries into bits 1..3 use ci directly rather than c[0], keeping each
  // carry a two-level expression.
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);

  assign s = p ^ c;

  // Group terms consumed by the second-level lookahead in the top.
  assign GG = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);
  assign GP = &p;

endmodule

// File: rtl/cla_8_bit.sv
// Eight-bit two-level carry-lookahead adder with a combinational result and
// a one-cycle registered copy for pipelined consumers.
module cla_8_bit
  import cla_8_bit_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CLA_WIDTH-1:0] A,
  input  logic [CLA_WIDTH-1:0] B,
  input  logic                 Cin,
  output logic [CLA_WIDTH-1:0] Sum,
  output logic                 Cout,
  output logic [CLA_WIDTH-1:0] Sum_q,
  output logic                 Cout_q
);

  localparam int WIDTH = CLA_WIDTH;

  logic [CLA_GROUPS-1:0] gg;
  logic [CLA_GROUPS-1:0] gp;
  logic [CLA_GROUPS-1:0] gci;

  operand_t sum_q_reg;
  logic     cout_q_reg;

  // Second-level lookahead: the upper group's carry-in is formed from the
  // lower group's GG/GP and Cin, never from the lower group's internal carries.
  assign gci[0] = Cin;
  assign gci[1] = gg[0] | (gp[0] & Cin);
  assign Cout   = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & Cin);

  genvar gi;
  generate
    for (gi = 0; gi < CLA_GROUPS; gi++) begin : g_group
      cla_4bit u_group (
        .a  (A[gi*CLA_GROUP +: CLA_GROUP]),
        .b  (B[gi*CLA_GROUP +: CLA_GROUP]),
        .ci (gci[gi]),
        .s  (Sum[gi*CLA_GROUP +: CLA_GROUP]),
        .GG (gg[gi]),
        .GP (gp[gi])
      );
    end
  endgenerate

  // Registered copy of the result; reset clears it without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q_reg  <= '0;
      cout_q_reg <= 1'b0;
    end else begin
      sum_q_reg  <= Sum;
      cout_q_reg <= Cout;
    end
  end

  assign Sum_q  = sum_q_reg[WIDTH-1:0];
  assign Cout_q = cout_q_reg;

endmodule

// File: tb/tb_cla_8_bit.sv
// Directed and exhaustive checks for cla_8_bit, combinational and registered.
module tb_cla_8_bit;

  logic       clk;
  logic       rst_n;
  logic [7:0] A;
  logic [7:0] B;
  logic       Cin;
  logic [7:0] Sum;
  logic       Cout;
  logic [7:0] Sum_q;
  logic       Cout_q;

  int n_checks = 0;
  int n_errors = 0;

  cla_8_bit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .A      (A),
    .B      (B),
    .Cin    (Cin),
    .Sum    (Sum),
    .Cout   (Cout),
    .Sum_q  (Sum_q),
    .Cout_q (Cout_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic cin);
    A   = a;
    B   = b;
    Cin = cin;
    #1;
  endtask

  // Directed vectors with hand-computed results.
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  vec_t vecs[7] = '{
    '{8'd69,  8'd42,  1'b0, 8'd111, 1'b0},
    '{8'd69,  8'd42,  1'b1, 8'd112, 1'b0},
    '{8'd128, 8'd128, 1'b0, 8'd0,   1'b1},
    '{8'd128, 8'd127, 1'b1, 8'd0,   1'b1},
    '{8'd15,  8'd0,   1'b1, 8'd16,  1'b0},
    '{8'd255, 8'd0,   1'b1, 8'd0,   1'b1},
    '{8'd255, 8'd255, 1'b1, 8'd255, 1'b1}
  };

  initial begin
    logic [8:0] exp9;
    rst_n = 1'b0;
    A = 8'd0;
    B = 8'd0;
    Cin = 1'b0;
    #1;
    check("reset_sum_q", {8'd0, Sum_q}, 16'd0);
    check("reset_cout_q", {15'd0, Cout_q}, 16'd0);

    // Register held in reset across a clock edge with a nonzero sum present.
    drive(8'd69, 8'd42, 1'b0);
    @(posedge clk); #1;
    check("held_reset_sum_q", {8'd0, Sum_q}, 16'd0);

    @(negedge clk);
    rst_n = 1'b1;

    // Directed combinational vectors, each followed by its registered copy.
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].a, vecs[i].b, vecs[i].cin);
      $display("vec %0d: %0d + %0d + %0d -> Sum=%0d Cout=%0d", i, vecs[i].a, vecs[i].b,
               vecs[i].cin, Sum, Cout);
      check($sformatf("sum_v%0d", i), {8'd0, Sum}, {8'd0, vecs[i].sum});
      check($sformatf("cout_v%0d", i), {15'd0, Cout}, {15'd0, vecs[i].cout});
      @(posedge clk); #1;
      check($sformatf("sum_q_v%0d", i), {8'd0, Sum_q}, {8'd0, vecs[i].sum});
      check($sformatf("cout_q_v%0d", i), {15'd0, Cout_q}, {15'd0, vecs[i].cout});
    end

    // Asynchronous reset between edges: register clears, combinational path holds.
    @(negedge clk);
    drive(8'd69, 8'd42, 1'b0);
    @(posedge clk); #1;
    check("load_sum_q", {8'd0, Sum_q}, 16'd111);
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset: Sum_q=%0d Cout_q=%0d Sum=%0d", Sum_q, Cout_q, Sum);
    check("async_rst_sum_q", {8'd0, Sum_q}, 16'd0);
    check("async_rst_cout_q", {15'd0, Cout_q}, 16'd0);
    check("async_rst_sum", {8'd0, Sum}, 16'd111);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("released_before_edge", {8'd0, Sum_q}, 16'd0);
    @(posedge clk); #1;
    check("reload_sum_q", {8'd0, Sum_q}, 16'd111);

    // Exhaustive combinational sweep against the 9-bit reference sum.
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        for (int c = 0; c < 2; c++) begin
          A = a[7:0];
          B = b[7:0];
          Cin = c[0];
          exp9 = 9'(a + b + c);
          #1;
          check($sformatf("sweep_%0d_%0d_%0d", a, b, c), {7'd0, Cout, Sum}, {7'd0, exp9});
        end
      end
    end
    $display("exhaustive sweep done: %0d checks so far", n_checks);

    // Registered copy over a strided subset, one cycle after each drive.
    for (int a = 0; a < 256; a += 5) begin
      for (int b = 0; b < 256; b += 7) begin
        for (int c = 0; c < 2; c++) begin
          @(negedge clk);
          A = a[7:0];
          B = b[7:0];
          Cin = c[0];
          exp9 = 9'(a + b + c);
          @(posedge clk); #1;
          check($sformatf("reg_%0d_%0d_%0d", a, b, c), {7'd0, Cout_q, Sum_q}, {7'd0, exp9});
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cla_8_bit.md
# cla_8_bit

Eight-bit two-level carry-lookahead adder for the VLIW datapath ALU lanes. A combinational sum/carry path serves same-cycle consumers, and a registered copy of the same result serves pipelined consumers. No ripple carry chain: every carry comes from lookahead equations.

## Interface
Parameters:
- WIDTH, 8, operand width; fixed at 8, not overridable.

Ports:
- clk  input  1  rising-edge clock for the registered result.
- rst_n  input  1  reset, asynchronous and active-low; clears the registered result.
- A  input  8  operand A, unsigned.
- B  input  8  operand B, unsigned.
- Cin  input  1  carry-in.
- Sum  output  8  combinational (A + B + Cin) mod 256.
- Cout  output  1  combinational carry-out, bit 8 of A + B + Cin.
- Sum_q  output  8  Sum registered on clk.
- Cout_q  output  1  Cout registered on clk.

## Operation
- Bit level: g[i] = A[i] & B[i]; p[i] = A[i] ^ B[i]; Sum[i] = p[i] ^ c[i]; c[0] = Cin.
- Bits split into two 4-bit groups: [3:0] and [7:4].
- Within each group, carries are computed by full lookahead from the group carry-in.
  - Example: c1 = g0 | p0&ci; c2 = g1 | p1&g0 | p1&p0&ci; c3 likewise.
- Each group also outputs a group generate and a group propagate.
  - GG = g3 | p3&g2 | p3&p2&g1 | p3&p2&p1&g0.
  - GP = p3&p2&p1&p0.
- Second level:
  - c4 = GG0 | GP0&Cin.
  - Cout = GG1 | GP1&GG0 | GP1&GP0&Cin.
- Result requirement: {Cout, Sum} equals the 9-bit value A + B + Cin for all 2^17 input combinations.
- Wrap-around: 255 + 0 + 1 gives Sum = 0, Cout = 1. 255 + 255 + 1 gives Sum = 255, Cout = 1.
- No signed overflow flag. Operands are treated as unsigned.

## Timing
- Sum and Cout are purely combinational.
  - They settle within the same evaluation after A, B or Cin change.
  - They are independent of clk and rst_n, and stay valid with clk idle.
  - They have no reset value.
- Sum_q and Cout_q capture Sum and Cout on every rising clk edge. Latency is 1 cycle and there is no enable.
- Reset:
  - rst_n low forces Sum_q = 0 and Cout_q = 0 immediately, without waiting for a clock edge.
  - This holds while rst_n stays low.
  - The first rising edge after rst_n goes high loads the current Sum and Cout.
- Reset asserted mid-operation: the registered outputs clear at once; the combinational outputs are unaffected.
- Simultaneous reset release and clock edge: the register stays 0 for that edge.

## Structure
- Shared package holds:
  - CLA_WIDTH = 8.
  - CLA_GROUP = 4.
  - A typedef for the 8-bit operand type.
- One sub-module, cla_4bit.
  - Inputs: 4-bit a, 4-bit b, ci.
  - Outputs: 4-bit s, GG, GP.
  - Instantiated twice.
- Top level holds:
  - The second-level lookahead, which produces c4 and Cout.
  - The output register.

## Test plan
- A=69, B=42, Cin=0 -> Sum=111, Cout=0; after one clk edge, Sum_q=111, Cout_q=0.
- A=69, B=42, Cin=1 -> Sum=112, Cout=0.
- A=128, B=128, Cin=0 -> Sum=0, Cout=1. A=128, B=127, Cin=1 -> Sum=0, Cout=1.
- Carry-propagation boundaries:
  - A=15, B=0, Cin=1 -> Sum=16, Cout=0 (carry crosses the group boundary).
  - A=255, B=0, Cin=1 -> Sum=0, Cout=1.
  - A=255, B=255, Cin=1 -> Sum=255, Cout=1.
- Reset and register behaviour:
  - Load Sum_q=111, then pull rst_n low between clock edges -> Sum_q=0 and Cout_q=0 immediately, while Sum stays 111.
  - Release rst_n -> the next rising edge reloads Sum_q.
- Exhaustive sweep of all A, B and Cin -> {Cout, Sum} == A + B + Cin every time, and the registered copy matches one cycle later.
